// File: rtl/inst_fetch_queue_pkg.sv
// rtl/inst_fetch_queue_pkg.sv - shared state encoding and counter sizing for the fetch queue
package inst_fetch_queue_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } ifq_state_e;

    // Bits needed to hold every value 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/inst_fetch_queue_sync_fifo.sv
// rtl/inst_fetch_queue_sync_fifo.sv - synchronous FIFO with flush, used as the instruction queue
import inst_fetch_queue_pkg::*;

module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             pop_fire;
    logic             push_fire;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_FULL);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a full queue can still accept a push.
    assign pop_fire  = pop && !empty;
    assign push_fire = push && (!full || pop_fire);

    // Pointer, occupancy and storage updates; flush discards everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_fire) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
            end
            if (pop_fire) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
            end
            case ({push_fire, pop_fire})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - credit-limited instruction fetch engine with redirect and drain
import inst_fetch_queue_pkg::*;

module inst_fetch_queue #(
    parameter int PC_BIT          = 8,
    parameter int INST_ID_BIT     = 8,
    parameter int INST_W          = 32,
    parameter int QUEUE_DEPTH     = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int PC_STEP         = 1,
    parameter int NUM_FU          = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   fetch_vld,
    input  logic                   fetch_rdy,
    output logic [INST_ID_BIT-1:0] fetch_id,
    output logic [PC_BIT-1:0]      fetch_pc,
    input  logic                   resp_vld,
    output logic                   resp_rdy,
    input  logic                   resp_last,
    input  logic [INST_W-1:0]      resp_data,
    output logic                   inst_vld,
    input  logic                   inst_rdy,
    output logic                   inst_last,
    output logic [INST_W-1:0]      inst_data,
    input  logic                   redirect_vld,
    input  logic [PC_BIT-1:0]      redirect_pc,
    input  logic [NUM_FU-1:0]      fu_idle,
    output logic                   exec_finish
);

    localparam int CNT_W  = cnt_width(MAX_OUTSTANDING);
    localparam int QCNT_W = cnt_width(QUEUE_DEPTH);
    localparam logic [CNT_W-1:0]       CNT_ONE = CNT_W'(1);
    localparam logic [INST_ID_BIT-1:0] ID_ONE  = INST_ID_BIT'(1);
    localparam logic [PC_BIT-1:0]      PC_INC  = PC_BIT'(PC_STEP);

    ifq_state_e             state_q, state_d;
    logic [INST_ID_BIT-1:0] fetch_id_q, fetch_id_d;
    logic [PC_BIT-1:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]       outstanding_q, outstanding_d;
    logic [CNT_W-1:0]       drop_q, drop_d;

    logic [QCNT_W-1:0]      q_count;
    logic                   q_empty;
    logic [INST_W:0]        q_head;
    logic                   redirect_act;
    logic                   fetch_fire;
    logic                   resp_keep;
    logic                   inst_fire;
    logic                   credit_ok;
    logic [31:0]            inflight_sum;
    logic [31:0]            reserved_sum;
    logic [CNT_W-1:0]       fetch_inc;
    logic [CNT_W-1:0]       resp_dec;

    // Redirect is meaningless once the program has finished.
    assign redirect_act = redirect_vld && (state_q != DONE);

    // Credits: in-flight (kept + doomed) requests are capped, and every kept request
    // already owns a queue slot, so the queue can never overflow.
    assign inflight_sum = 32'(outstanding_q) + 32'(drop_q);
    assign reserved_sum = 32'(outstanding_q) + 32'(q_count);
    assign credit_ok    = (inflight_sum < 32'(MAX_OUTSTANDING)) && (reserved_sum < 32'(QUEUE_DEPTH));

    assign fetch_vld  = (state_q == FETCH) && !redirect_vld && credit_ok;
    assign fetch_fire = fetch_vld && fetch_rdy;
    assign fetch_id   = fetch_id_q;
    assign fetch_pc   = fetch_pc_q;
    assign resp_rdy   = 1'b1;

    assign resp_keep  = resp_vld && !redirect_act && (drop_q == '0);
    assign inst_vld   = !q_empty;
    assign inst_last  = q_head[INST_W];
    assign inst_data  = q_head[INST_W-1:0];
    assign inst_fire  = inst_vld && inst_rdy;

    assign exec_finish = (state_q == DONE) && (&fu_idle);

    assign fetch_inc = fetch_fire ? CNT_ONE : '0;
    assign resp_dec  = resp_vld ? CNT_ONE : '0;

    sync_fifo #(
        .WIDTH (INST_W + 1),
        .DEPTH (QUEUE_DEPTH),
        .CNT_W (QCNT_W)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_act),
        .push      (resp_keep),
        .push_data ({resp_last, resp_data}),
        .pop       (inst_rdy),
        .pop_data  (q_head),
        .empty     (q_empty),
        .count     (q_count)
    );

    // Next-state, fetch address/id and response bookkeeping.
    always_comb begin
        state_d       = state_q;
        fetch_id_d    = fetch_id_q;
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + fetch_inc;
        drop_d        = drop_q;

        if (fetch_fire) begin
            fetch_id_d = fetch_id_q + ID_ONE;
            fetch_pc_d = fetch_pc_q + PC_INC;
        end

        if (redirect_act) begin
            // Every kept request becomes stale; a response arriving now is itself discarded.
            fetch_pc_d    = redirect_pc;
            drop_d        = drop_q + outstanding_q - resp_dec;
            outstanding_d = '0;
            state_d       = FETCH;
        end else begin
            if (resp_vld) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CNT_ONE;
                end else if (resp_last) begin
                    // Requests past the final instruction (including one issued this cycle) are unwanted.
                    drop_d        = drop_q + outstanding_q + fetch_inc - CNT_ONE;
                    outstanding_d = '0;
                    if (state_q == FETCH) begin
                        state_d = DRAIN;
                    end
                end else begin
                    outstanding_d = outstanding_q + fetch_inc - CNT_ONE;
                end
            end
            if ((state_q == DRAIN) && inst_fire && inst_last) begin
                state_d = DONE;
            end
        end
    end

    // Architectural state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH;
            fetch_id_q    <= '0;
            fetch_pc_q    <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            fetch_id_q    <= fetch_id_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - directed self-checking bench for inst_fetch_queue
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_vld, fetch_rdy;
    logic [7:0]  fetch_id, fetch_pc;
    logic        resp_vld, resp_rdy, resp_last;
    logic [31:0] resp_data;
    logic        inst_vld, inst_rdy, inst_last;
    logic [31:0] inst_data;
    logic        redirect_vld;
    logic [7:0]  redirect_pc;
    logic [7:0]  fu_idle;
    logic        exec_finish;

    logic        fetch_vld_w, fetch_rdy_w;
    logic [7:0]  fetch_id_w, fetch_pc_w;
    logic        resp_vld_w, resp_rdy_w, resp_last_w;
    logic [31:0] resp_data_w;
    logic        inst_vld_w, inst_rdy_w, inst_last_w;
    logic [31:0] inst_data_w;
    logic        redirect_vld_w;
    logic [7:0]  redirect_pc_w;
    logic [7:0]  fu_idle_w;
    logic        exec_finish_w;

    int passed = 0;
    int total = 0;
    int cyc = 0;
    int resp_delay = 3;
    int last_id = -1;
    int pend_id[$];
    int pend_due[$];
    int rec_id[$];
    int rec_pc[$];
    logic [31:0] pop_data[$];
    logic        pop_last[$];

    always #5 clk = ~clk;

    inst_fetch_queue dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_vld(fetch_vld), .fetch_rdy(fetch_rdy), .fetch_id(fetch_id), .fetch_pc(fetch_pc),
        .resp_vld(resp_vld), .resp_rdy(resp_rdy), .resp_last(resp_last), .resp_data(resp_data),
        .inst_vld(inst_vld), .inst_rdy(inst_rdy), .inst_last(inst_last), .inst_data(inst_data),
        .redirect_vld(redirect_vld), .redirect_pc(redirect_pc), .fu_idle(fu_idle),
        .exec_finish(exec_finish)
    );

    inst_fetch_queue #(.PC_STEP(4)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .fetch_vld(fetch_vld_w), .fetch_rdy(fetch_rdy_w), .fetch_id(fetch_id_w), .fetch_pc(fetch_pc_w),
        .resp_vld(resp_vld_w), .resp_rdy(resp_rdy_w), .resp_last(resp_last_w), .resp_data(resp_data_w),
        .inst_vld(inst_vld_w), .inst_rdy(inst_rdy_w), .inst_last(inst_last_w), .inst_data(inst_data_w),
        .redirect_vld(redirect_vld_w), .redirect_pc(redirect_pc_w), .fu_idle(fu_idle_w),
        .exec_finish(exec_finish_w)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        fetch_rdy = 1'b0; resp_vld = 1'b0; resp_last = 1'b0; resp_data = '0;
        inst_rdy = 1'b0; redirect_vld = 1'b0; redirect_pc = '0; fu_idle = 8'hFF;
        fetch_rdy_w = 1'b0; resp_vld_w = 1'b0; resp_last_w = 1'b0; resp_data_w = '0;
        inst_rdy_w = 1'b0; redirect_vld_w = 1'b0; redirect_pc_w = '0; fu_idle_w = 8'hFF;
        pend_id.delete(); pend_due.delete(); rec_id.delete(); rec_pc.delete();
        pop_data.delete(); pop_last.delete();
        last_id = -1; resp_delay = 3;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc = 0;
    endtask

    // One clock of environment: memory returns responses resp_delay cycles after each fetch.
    task automatic cycle();
        resp_vld = 1'b0; resp_last = 1'b0; resp_data = '0;
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            resp_vld  = 1'b1;
            resp_data = 32'hA000_0000 | 32'(pend_id[0]);
            resp_last = (pend_id[0] == last_id);
            void'(pend_due.pop_front());
            void'(pend_id.pop_front());
        end
        #1;
        if (fetch_vld && fetch_rdy) begin
            rec_id.push_back(int'(fetch_id));
            rec_pc.push_back(int'(fetch_pc));
            pend_id.push_back(int'(fetch_id));
            pend_due.push_back(cyc + resp_delay);
        end
        if (inst_vld && inst_rdy) begin
            pop_data.push_back(inst_data);
            pop_last.push_back(inst_last);
        end
        @(posedge clk);
        #1;
        resp_vld = 1'b0; resp_last = 1'b0;
        cyc++;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (fetch_vld !== 1'b1) $display("FAIL reset_fetch_vld got %0b want 1", fetch_vld); else passed++;
        total++; if (fetch_pc !== 8'h00) $display("FAIL reset_fetch_pc got %0h want 0", fetch_pc); else passed++;
        total++; if (fetch_id !== 8'h00) $display("FAIL reset_fetch_id got %0h want 0", fetch_id); else passed++;
        total++; if (inst_vld !== 1'b0) $display("FAIL reset_inst_vld got %0b want 0", inst_vld); else passed++;
        total++; if (exec_finish !== 1'b0) $display("FAIL reset_exec_finish got %0b want 0", exec_finish); else passed++;
        total++; if (resp_rdy !== 1'b1) $display("FAIL reset_resp_rdy got %0b want 1", resp_rdy); else passed++;
    endtask

    task automatic test_credit_limit();
        do_reset();
        fetch_rdy = 1'b1; inst_rdy = 1'b0;
        repeat (10) cycle();
        total++; if (rec_id.size() !== 4) $display("FAIL credit_fetch_count got %0d want 4", rec_id.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++; if (rec_id[i] !== i) $display("FAIL credit_fetch_id[%0d] got %0d want %0d", i, rec_id[i], i); else passed++;
        end
        total++; if (rec_pc[3] !== 3) $display("FAIL credit_fetch_pc3 got %0d want 3", rec_pc[3]); else passed++;
        total++; if (fetch_vld !== 1'b0) $display("FAIL credit_fetch_vld_full got %0b want 0", fetch_vld); else passed++;
        total++; if (inst_vld !== 1'b1) $display("FAIL credit_inst_vld got %0b want 1", inst_vld); else passed++;
        total++; if (inst_data !== 32'hA000_0000) $display("FAIL credit_head_stable got %0h want a0000000", inst_data); else passed++;
        fetch_rdy = 1'b0; inst_rdy = 1'b1;
        repeat (5) cycle();
        total++; if (pop_data.size() !== 4) $display("FAIL credit_pop_count got %0d want 4", pop_data.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (pop_data[i] !== (32'hA000_0000 | 32'(i))) $display("FAIL credit_pop_order[%0d] got %0h want %0h", i, pop_data[i], 32'hA000_0000 | 32'(i));
            else passed++;
        end
        total++; if (inst_vld !== 1'b0) $display("FAIL credit_drained got %0b want 0", inst_vld); else passed++;
    endtask

    task automatic test_redirect();
        do_reset();
        fetch_rdy = 1'b1; inst_rdy = 1'b1;
        repeat (3) cycle();
        fetch_rdy = 1'b0; redirect_vld = 1'b1; redirect_pc = 8'h40;
        cycle();
        redirect_vld = 1'b0; fetch_rdy = 1'b1;
        cycle();
        fetch_rdy = 1'b0;
        repeat (2) cycle();
        total++; if (inst_vld !== 1'b0) $display("FAIL redirect_queue_empty got %0b want 0", inst_vld); else passed++;
        repeat (4) cycle();
        total++; if (rec_id.size() !== 4) $display("FAIL redirect_fetch_count got %0d want 4", rec_id.size()); else passed++;
        total++; if (rec_pc[3] !== 32'h40) $display("FAIL redirect_new_pc got %0h want 40", rec_pc[3]); else passed++;
        total++; if (rec_id[3] !== 3) $display("FAIL redirect_id_continues got %0d want 3", rec_id[3]); else passed++;
        total++; if (pop_data.size() !== 1) $display("FAIL redirect_stale_dropped got %0d issued want 1", pop_data.size()); else passed++;
        total++; if (pop_data[0] !== 32'hA000_0003) $display("FAIL redirect_issued_data got %0h want a0000003", pop_data[0]); else passed++;
        total++; if (fetch_pc !== 8'h41) $display("FAIL redirect_pc_advance got %0h want 41", fetch_pc); else passed++;
    endtask

    task automatic test_last_and_done();
        do_reset();
        last_id = 2;
        fetch_rdy = 1'b1; inst_rdy = 1'b1;
        repeat (12) cycle();
        total++; if (rec_id.size() !== 5) $display("FAIL last_fetch_count got %0d want 5", rec_id.size()); else passed++;
        total++; if (rec_pc[4] !== 4) $display("FAIL last_fetch_pc4 got %0d want 4", rec_pc[4]); else passed++;
        total++; if (pop_data.size() !== 3) $display("FAIL last_issued_count got %0d want 3", pop_data.size()); else passed++;
        total++; if (pop_data[2] !== 32'hA000_0002) $display("FAIL last_item_data got %0h want a0000002", pop_data[2]); else passed++;
        total++; if (pop_last[2] !== 1'b1) $display("FAIL last_flag_item2 got %0b want 1", pop_last[2]); else passed++;
        total++; if (pop_last[1] !== 1'b0) $display("FAIL last_flag_item1 got %0b want 0", pop_last[1]); else passed++;
        total++; if (fetch_vld !== 1'b0) $display("FAIL last_no_fetch got %0b want 0", fetch_vld); else passed++;
        total++; if (inst_vld !== 1'b0) $display("FAIL last_queue_empty got %0b want 0", inst_vld); else passed++;
        fu_idle = 8'hFF; #1;
        total++; if (exec_finish !== 1'b1) $display("FAIL done_finish_idle got %0b want 1", exec_finish); else passed++;
        fu_idle = 8'hFE; #1;
        total++; if (exec_finish !== 1'b0) $display("FAIL done_finish_fu0_busy got %0b want 0", exec_finish); else passed++;
        fu_idle = 8'h7F; #1;
        total++; if (exec_finish !== 1'b0) $display("FAIL done_finish_fu7_busy got %0b want 0", exec_finish); else passed++;
        fu_idle = 8'hFF; redirect_vld = 1'b1; redirect_pc = 8'h80;
        cycle();
        redirect_vld = 1'b0; #1;
        total++; if (exec_finish !== 1'b1) $display("FAIL done_redirect_ignored got %0b want 1", exec_finish); else passed++;
        total++; if (fetch_pc !== 8'h05) $display("FAIL done_redirect_pc got %0h want 05", fetch_pc); else passed++;
        total++; if (fetch_vld !== 1'b0) $display("FAIL done_redirect_fetch got %0b want 0", fetch_vld); else passed++;
    endtask

    task automatic test_pc_wrap();
        do_reset();
        redirect_vld_w = 1'b1; redirect_pc_w = 8'hFC;
        @(posedge clk); #1;
        redirect_vld_w = 1'b0; fetch_rdy_w = 1'b1; #1;
        total++; if (fetch_vld_w !== 1'b1) $display("FAIL wrap_fetch_vld got %0b want 1", fetch_vld_w); else passed++;
        total++; if (fetch_pc_w !== 8'hFC) $display("FAIL wrap_start_pc got %0h want fc", fetch_pc_w); else passed++;
        @(posedge clk); #1;
        total++; if (fetch_pc_w !== 8'h00) $display("FAIL wrap_pc got %0h want 00", fetch_pc_w); else passed++;
        total++; if (fetch_id_w !== 8'h01) $display("FAIL wrap_id got %0h want 01", fetch_id_w); else passed++;
        fetch_rdy_w = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        fetch_rdy = 1'b1; inst_rdy = 1'b0;
        repeat (6) cycle();
        total++; if (inst_vld !== 1'b1) $display("FAIL midrst_pre_inst_vld got %0b want 1", inst_vld); else passed++;
        total++; if (fetch_pc !== 8'h04) $display("FAIL midrst_pre_pc got %0h want 04", fetch_pc); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (inst_vld !== 1'b0) $display("FAIL midrst_inst_vld got %0b want 0", inst_vld); else passed++;
        total++; if (fetch_pc !== 8'h00) $display("FAIL midrst_fetch_pc got %0h want 00", fetch_pc); else passed++;
        total++; if (fetch_vld !== 1'b1) $display("FAIL midrst_fetch_vld got %0b want 1", fetch_vld); else passed++;
        total++; if (fetch_id !== 8'h00) $display("FAIL midrst_fetch_id got %0h want 00", fetch_id); else passed++;
    endtask

    initial begin
        test_reset();
        test_credit_limit();
        test_redirect();
        test_last_and_done();
        test_pc_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
